// File: rtl/snitch_acc_sched.sv
// Shared-FU offload scheduler: RR arbitration, ID extension, response routing.
// Optional stall counters enabled by SNITCH_ACC_SCHED_STALL_CNT_EN.
module snitch_acc_sched #(
  parameter int unsigned CoreCount      = 4,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned PayloadWidth   = 128,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned LogCoreCount  =
    (CoreCount > 1) ? $clog2(CoreCount) : 1,
  localparam int unsigned ExtIdWidth    = IdWidth + LogCoreCount,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [CoreCount-1:0]                    core_qvalid_i,
  output logic [CoreCount-1:0]                    core_qready_o,
  input  logic [CoreCount-1:0][IdWidth-1:0]       core_qid_i,
  input  logic [CoreCount-1:0][PayloadWidth-1:0]  core_qpayload_i,
  output logic                                    sfu_qvalid_o,
  input  logic                                    sfu_qready_i,
  output logic [ExtIdWidth-1:0]                   sfu_qid_o,
  output logic [PayloadWidth-1:0]                 sfu_qpayload_o,
  input  logic                                    sfu_pvalid_i,
  output logic                                    sfu_pready_o,
  input  logic [ExtIdWidth-1:0]                   sfu_pid_i,
  input  logic [DataWidth-1:0]                    sfu_pdata_i,
  input  logic                                    sfu_perror_i,
  output logic [CoreCount-1:0]                    core_pvalid_o,
  input  logic [CoreCount-1:0]                    core_pready_i,
  output logic [IdWidth-1:0]                      core_pid_o,
  output logic [DataWidth-1:0]                    core_pdata_o,
  output logic                                    core_perror_o,
  input  logic                                    drain_i,
  output logic                                    idle_o,
  output logic [CoreCount-1:0][31:0]              stall_cnt_o
);

  logic [LogCoreCount-1:0] ptr_q, ptr_d;
  logic                    qvalid_q;
  logic [ExtIdWidth-1:0]   qid_q;
  logic [PayloadWidth-1:0] qpay_q;

  logic [CoreCount-1:0][CntWidth-1:0] cnt_q, cnt_d;

  logic [CoreCount-1:0]    below_max;
  logic [CoreCount-1:0]    elig;
  logic                    gnt_valid;
  logic [LogCoreCount-1:0] gnt_idx;
  logic [IdWidth-1:0]      gnt_qid;
  logic [PayloadWidth-1:0] gnt_pay;
  logic                    accept;
  int                      best;

  logic [LogCoreCount-1:0] sel;
  logic [CoreCount-1:0]    hit;
  logic                    sel_ok;
  logic [CoreCount-1:0]    inc, dec;

  always_comb begin
    for (int i = 0; i < int'(CoreCount); i++) begin
      below_max[i] = cnt_q[i] < CntWidth'(MaxOutstanding);
    end
  end

  assign elig = core_qvalid_i & below_max & {CoreCount{!drain_i}};

  // Pick the eligible core with the smallest distance from the pointer
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_qid   = '0;
    gnt_pay   = '0;
    best      = int'(CoreCount);
    for (int i = 0; i < int'(CoreCount); i++) begin
      if (elig[i] &&
          ((i - int'(ptr_q) + int'(CoreCount)) % int'(CoreCount)) < best) begin
        best      = (i - int'(ptr_q) + int'(CoreCount)) % int'(CoreCount);
        gnt_valid = 1'b1;
        gnt_idx   = LogCoreCount'(i);
        gnt_qid   = core_qid_i[i];
        gnt_pay   = core_qpayload_i[i];
      end
    end
  end

  assign accept = gnt_valid && (!qvalid_q || sfu_qready_i);

  always_comb begin
    core_qready_o = '0;
    for (int i = 0; i < int'(CoreCount); i++) begin
      core_qready_o[i] = accept && (gnt_idx == LogCoreCount'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = LogCoreCount'((int'(gnt_idx) + 1) % int'(CoreCount));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      qvalid_q <= 1'b0;
      qid_q    <= '0;
      qpay_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        qvalid_q <= 1'b1;
        qid_q    <= {gnt_idx, gnt_qid};
        qpay_q   <= gnt_pay;
      end else if (sfu_qready_i) begin
        qvalid_q <= 1'b0;
      end
    end
  end

  assign sfu_qvalid_o   = qvalid_q;
  assign sfu_qid_o      = qid_q;
  assign sfu_qpayload_o = qpay_q;

  // Responses with an out-of-range core index are swallowed
  assign sel = sfu_pid_i[ExtIdWidth-1:IdWidth];

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(CoreCount); i++) begin
      hit[i] = (sel == LogCoreCount'(i));
    end
  end

  assign sel_ok        = |hit;
  assign core_pvalid_o = {CoreCount{sfu_pvalid_i}} & hit;
  assign sfu_pready_o  = sel_ok ? |(hit & core_pready_i) : 1'b1;
  assign core_pid_o    = sfu_pid_i[IdWidth-1:0];
  assign core_pdata_o  = sfu_pdata_i;
  assign core_perror_o = sfu_perror_i;

  assign inc = core_qready_o;
  assign dec = core_pvalid_o & core_pready_i;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(CoreCount); i++) begin
      unique case ({inc[i], dec[i]})
        2'b10: cnt_d[i] = cnt_q[i] + CntWidth'(1);
        2'b01: begin
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CntWidth'(1);
        end
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idle_o = !qvalid_q && (cnt_q == '0);

`ifdef SNITCH_ACC_SCHED_STALL_CNT_EN
  logic [CoreCount-1:0][31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      for (int i = 0; i < int'(CoreCount); i++) begin
        if (core_qvalid_i[i] && !core_qready_o[i]) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  for (genvar g = 0; g < CoreCount; g++) begin : g_chk
    a_cnt_underflow: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(dec[g] && cnt_q[g] == '0))
      else $error("credit underflow on core %0d", g);
  end

  a_bad_sel: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(sfu_pvalid_i && !sel_ok))
    else $error("response to nonexistent core %0d", sel);
`endif

endmodule

// File: tb/tb_snitch_acc_sched.sv
// Randomized bench for snitch_acc_sched against a queue-based reference.
// Honors SNITCH_ACC_SCHED_STALL_CNT_EN for stall counter expectations.
module tb_snitch_acc_sched;

  localparam int N = 4;
  localparam int MAXO = 4;
`ifdef SNITCH_ACC_SCHED_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] core_qvalid_i, core_qready_o;
  logic [N-1:0][4:0] core_qid_i;
  logic [N-1:0][127:0] core_qpayload_i;
  logic sfu_qvalid_o, sfu_qready_i;
  logic [6:0] sfu_qid_o;
  logic [127:0] sfu_qpayload_o;
  logic sfu_pvalid_i, sfu_pready_o;
  logic [6:0] sfu_pid_i;
  logic [31:0] sfu_pdata_i;
  logic sfu_perror_i;
  logic [N-1:0] core_pvalid_o, core_pready_i;
  logic [4:0] core_pid_o;
  logic [31:0] core_pdata_o;
  logic core_perror_o, drain_i, idle_o;
  logic [N-1:0][31:0] stall_cnt_o;

  snitch_acc_sched dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_qvalid_i(core_qvalid_i), .core_qready_o(core_qready_o),
    .core_qid_i(core_qid_i), .core_qpayload_i(core_qpayload_i),
    .sfu_qvalid_o(sfu_qvalid_o), .sfu_qready_i(sfu_qready_i),
    .sfu_qid_o(sfu_qid_o), .sfu_qpayload_o(sfu_qpayload_o),
    .sfu_pvalid_i(sfu_pvalid_i), .sfu_pready_o(sfu_pready_o),
    .sfu_pid_i(sfu_pid_i), .sfu_pdata_i(sfu_pdata_i),
    .sfu_perror_i(sfu_perror_i),
    .core_pvalid_o(core_pvalid_o), .core_pready_i(core_pready_i),
    .core_pid_o(core_pid_o), .core_pdata_o(core_pdata_o),
    .core_perror_o(core_perror_o),
    .drain_i(drain_i), .idle_o(idle_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: credits, held slot, SFU in-flight FIFO
  int m_ptr;
  int m_cnt [N];
  bit m_hv;
  logic [6:0] m_hid;
  logic [127:0] m_hpay;
  logic [6:0] rq [$];
  logic [31:0] m_stall [N];

  int p_qv, p_srdy, p_prdy, p_pv, p_drain;
  logic [N-1:0] cmask;

  int acc_obs [N];
  int glog [$];

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic clear_obs();
    for (int c = 0; c < N; c++) acc_obs[c] = 0;
    glog.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    core_qvalid_i = '0;
    core_qid_i = '0;
    core_qpayload_i = '0;
    sfu_qready_i = 1'b0;
    sfu_pvalid_i = 1'b0;
    sfu_pid_i = '0;
    sfu_pdata_i = '0;
    sfu_perror_i = 1'b0;
    core_pready_i = '0;
    drain_i = 1'b0;
    m_ptr = 0;
    m_hv = 1'b0;
    m_hid = '0;
    m_hpay = '0;
    rq.delete();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0;
      m_stall[c] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_qvalid", sfu_qvalid_o, 0);
    check("rst_qready", core_qready_o, 0);
    check("rst_idle", idle_o, 1);
    check("rst_stall", stall_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    int gnt, s, tot;
    bit acc, hs;
    logic [N-1:0] e_qrdy, e_pv;
    logic [N-1:0][31:0] e_stall;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      core_qvalid_i[c] = cmask[c] && roll(p_qv);
      core_qid_i[c] = 5'($urandom);
      core_qpayload_i[c] = {$urandom, $urandom, $urandom, $urandom};
      core_pready_i[c] = roll(p_prdy);
    end
    sfu_qready_i = roll(p_srdy);
    drain_i = roll(p_drain);
    sfu_pdata_i = $urandom;
    sfu_perror_i = 1'($urandom);
    if (rq.size() > 0 && roll(p_pv)) begin
      sfu_pvalid_i = 1'b1;
      sfu_pid_i = rq[0];
    end else begin
      sfu_pvalid_i = 1'b0;
      sfu_pid_i = 7'($urandom);
    end
    #1;
    gnt = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (gnt < 0 && core_qvalid_i[c] && m_cnt[c] < MAXO && !drain_i)
        gnt = c;
    end
    acc = (gnt >= 0) && (!m_hv || sfu_qready_i);
    e_qrdy = '0;
    if (acc) e_qrdy[gnt] = 1'b1;
    s = int'(sfu_pid_i[6:5]);
    e_pv = '0;
    if (sfu_pvalid_i) e_pv[s] = 1'b1;
    hs = sfu_pvalid_i && core_pready_i[s];
    tot = 0;
    for (int c = 0; c < N; c++) tot += m_cnt[c];
    for (int c = 0; c < N; c++) e_stall[c] = STALL_EN ? m_stall[c] : 32'd0;

    check("qready", core_qready_o, e_qrdy);
    check("sfu_qvalid", sfu_qvalid_o, m_hv);
    if (m_hv) begin
      check("sfu_qid", sfu_qid_o, m_hid);
      check("sfu_qpayload", sfu_qpayload_o, m_hpay);
    end
    check("pvalid", core_pvalid_o, e_pv);
    check("sfu_pready", sfu_pready_o, core_pready_i[s]);
    check("pid", core_pid_o, sfu_pid_i[4:0]);
    check("pdata", core_pdata_o, sfu_pdata_i);
    check("perror", core_perror_o, sfu_perror_i);
    check("idle", idle_o, (!m_hv && tot == 0));
    check("stall", stall_cnt_o, e_stall);

    for (int c = 0; c < N; c++) begin
      if (core_qready_o[c] && core_qvalid_i[c]) begin
        acc_obs[c]++;
        glog.push_back(c);
      end
    end

    @(posedge clk);
    if (m_hv && sfu_qready_i) begin
      rq.push_back(m_hid);
      m_hv = 1'b0;
    end
    if (acc) begin
      m_hv = 1'b1;
      m_hid = {2'(gnt), core_qid_i[gnt]};
      m_hpay = core_qpayload_i[gnt];
      m_cnt[gnt]++;
      m_ptr = (gnt + 1) % N;
    end
    if (hs) begin
      m_cnt[s]--;
      void'(rq.pop_front());
    end
    for (int c = 0; c < N; c++)
      if (core_qvalid_i[c] && !e_qrdy[c]) m_stall[c] = m_stall[c] + 32'd1;
  endtask

  task automatic set_knobs(input logic [N-1:0] m, input int qv,
                           input int srdy, input int prdy,
                           input int pv, input int dr);
    cmask = m;
    p_qv = qv;
    p_srdy = srdy;
    p_prdy = prdy;
    p_pv = pv;
    p_drain = dr;
  endtask

  initial begin
    int tot;
    do_reset();

    // Round-robin with everything ready
    set_knobs(4'hF, 100, 100, 100, 100, 0);
    clear_obs();
    repeat (12) step();
    for (int k = 0; k < 5; k++) begin
      int g;
      g = (glog.size() > k) ? glog[k] : -1;
      check("rr_order", g, k % N);
    end
    check("rr_rate", glog.size(), 12);

    set_knobs(4'h0, 0, 100, 100, 100, 0);
    repeat (10) step();
    #1 check("idle_after_flush", idle_o, 1);

    // Core 2 alone against a silent SFU
    set_knobs(4'h4, 100, 100, 100, 0, 0);
    clear_obs();
    repeat (12) step();
    check("credit_limit", acc_obs[2], 4);
    check("qready2_blocked", core_qready_o[2], 0);
    p_pv = 100;
    step();
    p_pv = 0;
    repeat (6) step();
    check("credit_return", acc_obs[2], 5);

    // SFU back-pressure holds the request
    set_knobs(4'hF, 100, 0, 100, 100, 0);
    step();
    clear_obs();
    repeat (5) step();
    check("hold_no_accept", glog.size(), 0);
    p_srdy = 100;
    step();
    check("release_accept", glog.size(), 1);

    // Drain blocks new grants, in-flight work completes
    set_knobs(4'hF, 100, 100, 60, 100, 100);
    clear_obs();
    repeat (60) step();
    check("drain_no_accept", glog.size(), 0);
    #1 check("drain_idle", idle_o, 1);

    // Mixed random traffic
    set_knobs(4'hF, 60, 70, 70, 60, 5);
    repeat (2000) step();

    // Reset in the middle of traffic
    set_knobs(4'hF, 80, 50, 50, 0, 0);
    repeat (20) step();
    do_reset();
    set_knobs(4'hF, 60, 70, 70, 60, 5);
    repeat (300) step();

    // Core 0 blocked by a full credit counter
    do_reset();
    set_knobs(4'h1, 100, 100, 100, 0, 0);
    repeat (14) step();
    #1;
    check("stall_dir", stall_cnt_o[0], STALL_EN ? 32'd10 : 32'd0);
    tot = acc_obs[0];

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
